// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bundle for the fetch stage
interface fetch_stage_if #(
    parameter int XLEN = 32
) ();
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [31:0]     imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV32I instruction fetch + IF/ID register; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_f,
    input  logic              stall_d,
    input  logic              flush_d,
    input  logic              brn_taken_e,
    input  logic [XLEN-1:0]   brn_target_e,
    fetch_stage_if.master     imem,
    output logic [31:0]       instr_d,
    output logic [XLEN-1:0]   pc_d,
    output logic [XLEN-1:0]   pc_plus4_d,
    output logic              valid_d
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state_q;
    state_t          state_next;
    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] pc_next;
    logic            redirect_pend;
    logic            pend_next;
    logic [XLEN-1:0] pend_tgt;
    logic [XLEN-1:0] pend_tgt_next;
    logic            accept;
    logic [XLEN-1:0] brn_tgt;
    logic            unused_tgt_lsb;

    // Instructions are word aligned; the low target bits are dropped.
    assign brn_tgt        = {brn_target_e[XLEN-1:2], 2'b00};
    assign unused_tgt_lsb = ^brn_target_e[1:0];
    assign imem.imem_addr = pc_f;

    // Next-state, next-PC and redirect bookkeeping.
    always_comb begin
        state_next    = state_q;
        pc_next       = pc_f;
        pend_next     = redirect_pend;
        pend_tgt_next = pend_tgt;
        // A word is consumed only when nothing redirects or holds the front end.
        accept = imem.imem_req && imem.imem_ready && !stall_f && !redirect_pend && !brn_taken_e;

        case (state_q)
            BOOT:    state_next = FETCH;
            FETCH:   if (!imem.imem_ready) state_next = WAIT;
            WAIT:    if (imem.imem_ready) state_next = FETCH;
            default: state_next = BOOT;
        endcase

        if (brn_taken_e && imem.imem_req && !imem.imem_ready) begin
            // Outstanding request: keep the address stable, remember the target.
            pend_next     = 1'b1;
            pend_tgt_next = brn_tgt;
        end else if (brn_taken_e) begin
            pc_next   = brn_tgt;
            pend_next = 1'b0;
        end else if (redirect_pend && imem.imem_ready) begin
            // Late word from the old path completes and is dropped.
            pc_next   = pend_tgt;
            pend_next = 1'b0;
        end else if (accept) begin
            pc_next = pc_f + PC_STEP;
        end
    end

    // Front-end state register: FSM state, PC, pending redirect, request strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_f          <= RESET_PC;
            redirect_pend <= 1'b0;
            pend_tgt      <= '0;
            imem.imem_req <= 1'b0;
        end else begin
            state_q       <= state_next;
            pc_f          <= pc_next;
            redirect_pend <= pend_next;
            pend_tgt      <= pend_tgt_next;
            imem.imem_req <= (state_next != BOOT);
        end
    end

    // IF/ID register: flush/redirect > stall_d > accepted word > bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (flush_d || brn_taken_e) begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end else if (stall_d) begin
            instr_d <= instr_d;
            valid_d <= valid_d;
        end else if (accept) begin
            instr_d    <= imem.imem_rdata;
            pc_d       <= pc_f;
            pc_plus4_d <= pc_f + PC_STEP;
            valid_d    <= 1'b1;
        end else begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters of accepted words and wait/stall cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept && perf_fetch_cnt != 32'hFFFF_FFFF)
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((state_q == WAIT || stall_f) && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized model-checked bench for fetch_stage
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_f = 1'b0;
    logic        stall_d = 1'b0;
    logic        flush_d = 1'b0;
    logic        brn_taken_e = 1'b0;
    logic [31:0] brn_target_e = '0;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_stage_if #(.XLEN(32)) ifc ();

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .brn_taken_e  (brn_taken_e),
        .brn_target_e (brn_target_e),
        .imem         (ifc),
        .instr_d      (instr_d),
        .pc_d         (pc_d),
        .pc_plus4_d   (pc_plus4_d),
        .valid_d      (valid_d)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Reference model state: what the fetch stage must look like after each edge.
    bit          m_booted = 1'b0;
    bit          m_wait = 1'b0;
    bit          m_pend = 1'b0;
    logic [31:0] m_tgt = '0;
    logic [31:0] m_pc = '0;
    logic [31:0] m_instr = NOP;
    logic [31:0] m_pc_d = '0;
    bit          m_valid = 1'b0;
    logic [31:0] m_fcnt = '0;
    logic [31:0] m_scnt = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          req;
        bit          acc;
        logic [31:0] tgt;
        if (!rst_n) begin
            m_booted = 0; m_wait = 0; m_pend = 0; m_tgt = '0; m_pc = '0;
            m_instr = NOP; m_pc_d = '0; m_valid = 0; m_fcnt = '0; m_scnt = '0;
        end else begin
            req = m_booted;
            tgt = brn_target_e & 32'hFFFF_FFFC;
            acc = req && ifc.imem_ready && !stall_f && !m_pend && !brn_taken_e;
            if (flush_d || brn_taken_e) begin
                m_instr = NOP; m_valid = 0;
            end else if (!stall_d) begin
                if (acc) begin
                    m_instr = ifc.imem_rdata; m_pc_d = m_pc; m_valid = 1;
                end else begin
                    m_instr = NOP; m_valid = 0;
                end
            end
            if (brn_taken_e && req && !ifc.imem_ready) begin
                m_pend = 1; m_tgt = tgt;
            end else if (brn_taken_e) begin
                m_pc = tgt; m_pend = 0;
            end else if (m_pend && ifc.imem_ready) begin
                m_pc = m_tgt; m_pend = 0;
            end else if (acc) begin
                m_pc = m_pc + 32'd4;
            end
            if (acc && m_fcnt != '1) m_fcnt = m_fcnt + 1;
            if ((m_wait || stall_f) && m_scnt != '1) m_scnt = m_scnt + 1;
            m_wait = req && !ifc.imem_ready;
            m_booted = 1;
        end
    endtask

    // Model advances on the same events as the design.
    always @(posedge clk or negedge rst_n) model_step();

    // Compare every cycle, half a period away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("imem_req", {31'b0, ifc.imem_req}, {31'b0, m_booted});
            chk("imem_addr", ifc.imem_addr, m_pc);
            chk("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
            chk("instr_d", instr_d, m_instr);
            if (m_valid) begin
                chk("pc_d", pc_d, m_pc_d);
                chk("pc_plus4_d", pc_plus4_d, m_pc_d + 32'd4);
            end
`ifdef FETCH_PERF_CNT_EN
            chk("perf_fetch_cnt", perf_fetch_cnt, m_fcnt);
            chk("perf_stall_cnt", perf_stall_cnt, m_scnt);
`endif
        end
    end

    task automatic drive(input bit r, input bit sf, input bit sd, input bit fl,
                         input bit bt, input logic [31:0] t);
        ifc.imem_ready = r;
        ifc.imem_rdata = r ? mem_word(m_pc) : $urandom();
        stall_f      = sf;
        stall_d      = sd;
        flush_d      = fl;
        brn_taken_e  = bt;
        brn_target_e = t;
    endtask

    task automatic cyc(input bit r, input bit sf, input bit sd, input bit fl,
                       input bit bt, input logic [31:0] t);
        @(negedge clk);
        drive(r, sf, sd, fl, bt, t);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        ifc.imem_ready = 1'b0;
        ifc.imem_rdata = '0;
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'b0, ifc.imem_req}, 32'd0);
        chk("rst_instr", instr_d, NOP);
        chk("rst_pc_d", pc_d, 32'd0);
        chk("rst_pc_plus4", pc_plus4_d, 32'd0);
        chk("rst_valid", {31'b0, valid_d}, 32'd0);

        // Boot: one idle cycle, then words at 0,4,8.
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("boot_req", {31'b0, ifc.imem_req}, 32'd1);
        chk("boot_valid", {31'b0, valid_d}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            chk("seq_pc_d", pc_d, 32'(i * 4));
            chk("seq_valid", {31'b0, valid_d}, 32'd1);
        end
        chk("seq_instr", instr_d, 32'hFFF7_0008);

        // Run to 0x20, then branch to 0x103.
        repeat (5) cyc(1, 0, 0, 0, 0, 0);
        chk("pre_br_addr", ifc.imem_addr, 32'h20);
        cyc(1, 0, 0, 0, 1, 32'h103);
        chk("br_addr", ifc.imem_addr, 32'h100);
        chk("br_instr", instr_d, NOP);
        chk("br_valid", {31'b0, valid_d}, 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("br_pc_d", pc_d, 32'h100);

        // Three wait states at address 8.
        cyc(1, 0, 0, 0, 1, 32'h8);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0);
            chk("wait_addr", ifc.imem_addr, 32'h8);
            chk("wait_valid", {31'b0, valid_d}, 32'd0);
        end
        cyc(1, 0, 0, 0, 0, 0);
        chk("wait_pc_d", pc_d, 32'h8);
        chk("wait_pc_plus4", pc_plus4_d, 32'hC);

        // Branch to 0x40 while waiting at 0xC: the late word is dropped.
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 32'h40);
        chk("pend_addr", ifc.imem_addr, 32'hC);
        cyc(0, 0, 0, 0, 0, 0);
        chk("pend_addr2", ifc.imem_addr, 32'hC);
        cyc(1, 0, 0, 0, 0, 0);
        chk("late_valid", {31'b0, valid_d}, 32'd0);
        chk("late_addr", ifc.imem_addr, 32'h40);
        cyc(1, 0, 0, 0, 0, 0);
        chk("tgt_pc_d", pc_d, 32'h40);
        chk("tgt_instr", instr_d, 32'hFFBF_0040);

        // flush_d beats stall_d; then stall_d alone holds IF/ID.
        cyc(1, 0, 1, 1, 0, 0);
        chk("flush_valid", {31'b0, valid_d}, 32'd0);
        chk("flush_instr", instr_d, NOP);
        cyc(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 1, 0, 0, 0);
            chk("hold_pc_d", pc_d, 32'h48);
            chk("hold_instr", instr_d, 32'hFFB7_0048);
        end

        // PC wrap.
        cyc(1, 0, 0, 0, 1, 32'hFFFF_FFFE);
        cyc(1, 0, 0, 0, 0, 0);
        chk("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus4_d, 32'h0);
        chk("wrap_addr", ifc.imem_addr, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                            : ($urandom() & 32'hFFF);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0,
                $urandom_range(0, 6) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 19) == 0, t);
        end

        // Reset pulse in the middle of a wait state.
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, ifc.imem_req}, 32'd0);
        chk("mid_rst_addr", ifc.imem_addr, 32'd0);
        chk("mid_rst_valid", {31'b0, valid_d}, 32'd0);
        chk("mid_rst_instr", instr_d, NOP);
        chk("mid_rst_pc_d", pc_d, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("mid_rst_fcnt", perf_fetch_cnt, 32'd0);
        chk("mid_rst_scnt", perf_stall_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("restart_req", {31'b0, ifc.imem_req}, 32'd1);
        chk("restart_addr", ifc.imem_addr, 32'd0);
        cyc(1, 0, 0, 0, 0, 0);
        chk("restart_pc_d", pc_d, 32'd0);
        chk("restart_valid", {31'b0, valid_d}, 32'd1);
        cyc(1, 0, 0, 0, 0, 0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
